hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 50000, clock cycles each digit stays active (legal range 2..2^20).
REQ-002 Parameter: LZ_BLANK, default 1, enables leading-zero blanking when 1.
REQ-003 Port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: load  in  1  one-cycle strobe that requests capture of data_in.
REQ-006 Port: data_in  in  16  value to display as four hex nibbles; digit 3 = [15:12], digit 0 = [3:0].
REQ-007 Port: ack  out  1  one-cycle pulse confirming a load capture.
REQ-008 Port: nibble  out  4  binary nibble of the active digit; feeds the hex-to-7-segment decoder.
REQ-009 Port: digit_sel_n  out  4  active-low one-hot common-anode digit enable; bit i = digit i.
REQ-010 Port: blank  out  1  high when the active digit is suppressed; digit_sel_n is then 4'b1111.

Function
REQ-011 Internal state: prescaler (0..CLK_DIV-1), digit index idx (0..3), pend_reg[15:0], pend_flag, disp_reg[15:0].
REQ-012 Prescaler increments every cycle and wraps to 0 after CLK_DIV-1; the wrap cycle is the terminal count (tc).
REQ-013 On tc, idx advances 0->1->2->3->0; otherwise idx holds.
REQ-014 load=1 captures data_in into pend_reg and sets pend_flag on the same edge.
REQ-015 ack is 1 in the cycle after every cycle with load=1, including back-to-back loads.
REQ-016 On tc with idx=3 (frame wrap), disp_reg <= pend_reg and pend_flag clears if set; disp_reg changes at no other time (no tearing within a frame).
REQ-017 load on the same edge as a frame wrap: the frame wrap uses the old pend_reg; new data is held pending for the next frame wrap, and pend_flag stays 1.
REQ-018 Multiple loads within one frame: only the last captured value reaches disp_reg.
REQ-019 Blank rule: digit i (i=1..3) is blanked when LZ_BLANK=1 and disp_reg nibbles i..3 are all zero; digit 0 is never blanked.
REQ-020 nibble, digit_sel_n and blank are registered and reflect idx and disp_reg from the previous cycle (1-cycle latency).
REQ-021 When not blanked, digit_sel_n = ~(4'b0001 << idx); when blanked, digit_sel_n = 4'b1111 and nibble still carries the selected nibble.
REQ-022 At most one digit_sel_n bit is low in any cycle.

Reset
REQ-023 While rst_n=0: prescaler=0, idx=0, pend_reg=0, pend_flag=0, disp_reg=0, ack=0, nibble=0, digit_sel_n=4'b1111, blank=1.
REQ-024 Reset assertion mid-frame or mid-load takes effect immediately; pending data is discarded.
REQ-025 First edge after rst_n release yields nibble=0, digit_sel_n=4'b1110, blank=0.

Verification (CLK_DIV=4, LZ_BLANK=1 unless stated)
REQ-026 Release reset with no load -> digit_sel_n=1110, nibble=0 continuously; digits 1..3 blank=1 and digit_sel_n=1111 during their 4-cycle slots.
REQ-027 load with data_in=16'hA5C3 -> ack pulses one cycle later; after the next frame wrap, slots show nibble 3,C,5,A with digit_sel_n 1110,1101,1011,0111, each held 4 cycles.
REQ-028 load 16'h1234 then 16'h00F0 in the same frame -> 1234 never appears; next frame shows 0,F,blank,blank with blank=1 and digit_sel_n=1111 on digits 2 and 3.
REQ-029 load asserted on the frame-wrap edge -> that frame shows the previous value; the new value appears exactly one frame (16 cycles) later.
REQ-030 LZ_BLANK=0, data 16'h0000 -> all four digits enabled in turn with nibble=0, blank never 1.
REQ-031 rst_n pulsed low during the digit-2 slot with a load pending -> outputs take reset values asynchronously; after release, disp_reg=0 and the pending value is not displayed.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scan_ctrl
//  Brief    : Multiplexed 4-digit hex display scanner. The digits are scanned
//             in turn, each for CLK_DIV cycles. New data is double-buffered so
//             that it only reaches the display on a frame boundary. Leading
//             zeros can optionally be blanked.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl #(
    parameter int unsigned CLK_DIV  = 50000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic        ack,
    output logic [3:0]  nibble,
    output logic [3:0]  digit_sel_n,
    output logic        blank
);

    localparam int unsigned     c_PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PW-1:0] c_TC = c_PW'(CLK_DIV - 1);

    logic [c_PW-1:0] prescaler_q, prescaler_d;
    logic [1:0]      idx_q,       idx_d;
    logic [15:0]     pend_q,      pend_d;
    logic            pend_flag_q, pend_flag_d;
    logic [15:0]     disp_q,      disp_d;
    logic            ack_q,       ack_d;
    logic [3:0]      nibble_q,    nibble_d;
    logic [3:0]      sel_n_q,     sel_n_d;
    logic            blank_q,     blank_d;

    logic            w_tc;
    logic            w_frame_wrap;
    logic [3:0]      w_zero_above;

    // Next-state logic for the scan counters, buffers and display outputs.
    always_comb begin
        w_tc         = (prescaler_q == c_TC);
        w_frame_wrap = w_tc && (idx_q == 2'd3);

        prescaler_d  = w_tc ? '0 : prescaler_q + 1'b1;
        idx_d        = w_tc ? idx_q + 2'd1 : idx_q;

        // A load always lands in the pending buffer, even on a frame wrap:
        // the wrap then consumes the old pending value and the flag stays set.
        pend_d       = load ? data_in : pend_q;
        if (load) begin
            pend_flag_d = 1'b1;
        end else if (w_frame_wrap) begin
            pend_flag_d = 1'b0;
        end else begin
            pend_flag_d = pend_flag_q;
        end

        // Display buffer only changes at the frame boundary (no tearing).
        disp_d       = (w_frame_wrap && pend_flag_q) ? pend_q : disp_q;

        ack_d        = load;

        // w_zero_above[i]: nibbles i..3 of the displayed value are all zero.
        w_zero_above[3] = (disp_q[15:12] == 4'h0);
        w_zero_above[2] = w_zero_above[3] && (disp_q[11:8] == 4'h0);
        w_zero_above[1] = w_zero_above[2] && (disp_q[7:4]  == 4'h0);
        w_zero_above[0] = w_zero_above[1] && (disp_q[3:0]  == 4'h0);

        // Digit 0 is never blanked so a value of zero still shows "0".
        blank_d      = LZ_BLANK && (idx_q != 2'd0) && w_zero_above[idx_q];
        nibble_d     = disp_q[{idx_q, 2'b00} +: 4];
        sel_n_d      = blank_d ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    // State and registered outputs; reset clears everything including pending data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            idx_q       <= 2'd0;
            pend_q      <= 16'h0000;
            pend_flag_q <= 1'b0;
            disp_q      <= 16'h0000;
            ack_q       <= 1'b0;
            nibble_q    <= 4'h0;
            sel_n_q     <= 4'b1111;
            blank_q     <= 1'b1;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            disp_q      <= disp_d;
            ack_q       <= ack_d;
            nibble_q    <= nibble_d;
            sel_n_q     <= sel_n_d;
            blank_q     <= blank_d;
        end
    end

    assign ack         = ack_q;
    assign nibble      = nibble_q;
    assign digit_sel_n = sel_n_q;
    assign blank       = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_scan_ctrl
//  Brief    : Scoreboard bench for hex_scan_ctrl (CLK_DIV=4). Two instances
//             share the stimulus: one with leading-zero blanking, one without.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;

    logic        ack0, blank0, ack1, blank1;
    logic [3:0]  nib0, sel0, nib1, sel1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] edge_n;
        logic        ack;
        logic [3:0]  nib;
        logic [3:0]  sel;
        logic        blk;
        logic [3:0]  sel_nb;
    } exp_t;

    exp_t sb[$];
    int   e;

    hex_scan_ctrl #(.CLK_DIV(4), .LZ_BLANK(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
        .ack(ack0), .nibble(nib0), .digit_sel_n(sel0), .blank(blank0)
    );

    hex_scan_ctrl #(.CLK_DIV(4), .LZ_BLANK(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
        .ack(ack1), .nibble(nib1), .digit_sel_n(sel1), .blank(blank1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reset values on both instances.
    task automatic rst_chk(input string tag);
        chk({tag, " ack0"},   16'(ack0),   16'h0);
        chk({tag, " nib0"},   16'(nib0),   16'h0);
        chk({tag, " sel0"},   16'(sel0),   16'hF);
        chk({tag, " blank0"}, 16'(blank0), 16'h1);
        chk({tag, " ack1"},   16'(ack1),   16'h0);
        chk({tag, " nib1"},   16'(nib1),   16'h0);
        chk({tag, " sel1"},   16'(sel1),   16'hF);
        chk({tag, " blank1"}, 16'(blank1), 16'h1);
    endtask

    // Directed load schedule: edge number -> {load, data}.
    function automatic logic [16:0] ld_at(input int n);
        case (n)
            5:       return {1'b1, 16'hA5C3};
            20:      return {1'b1, 16'h1234};
            21:      return {1'b1, 16'h00F0};
            48:      return {1'b1, 16'hBEEF};   // load on the frame-wrap edge
            70:      return {1'b1, 16'h0007};
            98:      return {1'b1, 16'h0900};   // discarded by the reset pulse
            default: return {1'b0, 16'h0000};
        endcase
    endfunction

    // Hand-computed displayed value and blank mask (bit i = digit i) per frame.
    function automatic logic [19:0] frame_at(input int f);
        case (f)
            0:       return {16'h0000, 4'b1110};
            1:       return {16'hA5C3, 4'b0000};
            2:       return {16'h00F0, 4'b1100};
            3:       return {16'h00F0, 4'b1100};
            4:       return {16'hBEEF, 4'b0000};
            5:       return {16'h0007, 4'b1110};
            default: return {16'h0007, 4'b1110};
        endcase
    endfunction

    // One clock: drive inputs for the next edge and queue the expected outputs
    // after that edge. Called just after a falling edge.
    task automatic cyc(input logic ld, input logic [15:0] d,
                       input logic [15:0] dv, input logic [3:0] bk);
        exp_t       x;
        int         slot;
        logic [3:0] onehot;
        slot       = (e / 4) % 4;
        onehot     = 4'b0001 << slot;
        load       = ld;
        data_in    = d;
        x.edge_n   = 32'(e + 1);
        x.ack      = ld;
        x.nib      = dv[4*slot +: 4];
        x.blk      = bk[slot];
        x.sel      = bk[slot] ? 4'b1111 : ~onehot;
        x.sel_nb   = ~onehot;
        sb.push_back(x);
        @(negedge clk);
        e++;
    endtask

    // Monitor: compare every queued expectation just after its rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk($sformatf("e%0d ack0", x.edge_n),   16'(ack0),   16'(x.ack));
                chk($sformatf("e%0d nib0", x.edge_n),   16'(nib0),   16'(x.nib));
                chk($sformatf("e%0d sel0", x.edge_n),   16'(sel0),   16'(x.sel));
                chk($sformatf("e%0d blank0", x.edge_n), 16'(blank0), 16'(x.blk));
                chk($sformatf("e%0d ack1", x.edge_n),   16'(ack1),   16'(x.ack));
                chk($sformatf("e%0d nib1", x.edge_n),   16'(nib1),   16'(x.nib));
                chk($sformatf("e%0d sel1", x.edge_n),   16'(sel1),   16'(x.sel_nb));
                chk($sformatf("e%0d blank1", x.edge_n), 16'(blank1), 16'h0);
            end
        end
    end

    // Stimulus.
    initial begin
        logic [16:0] l;
        logic [19:0] fr;
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = 16'h0000;
        repeat (3) @(negedge clk);
        rst_chk("por");

        rst_n = 1'b1;
        e     = 0;
        for (int n = 1; n <= 106; n++) begin
            l  = ld_at(n);
            fr = frame_at((n - 1) / 16);
            cyc(l[16], l[15:0], fr[19:4], fr[3:0]);
        end

        // Reset mid digit-2 slot with 0900 pending: must act immediately.
        rst_n = 1'b0;
        #1;
        rst_chk("async");
        repeat (2) @(negedge clk);
        rst_chk("held");

        rst_n = 1'b1;
        e     = 0;
        for (int n = 1; n <= 32; n++) begin
            cyc(1'b0, 16'h0000, 16'h0000, 4'b1110);
        end
        load = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 16'(sb.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
